ex_mem_skid: RTL and testbench
==============================

// Module: ex_mem_skid
// PURPOSE
//  Two-entry skid buffer between the EX stage (ALU) and the MEM stage.
//  Captures the ALU result, NZCV flags, store data, destination register and
//  MEM/WB control bits, then presents them downstream under valid/ready.
//  Lets MEM stall (e.g. a slow data memory) without a combinational ready path
//  back into EX. Supports a synchronous flush on branch mispredict or trap.
// PARAMETERS
//  DATA_W  32  width of the ALU result and store data
//  FLAG_W   4  width of the NZCV flags (N=3, Z=2, C=1, V=0)
//  RD_W     5  width of the destination register index
//  CTRL_W   4  control bits {MemRead, MemWrite, RegWrite, MemtoReg}, MSB first
// PORTS
//  clk_i          in   1       clock, all state on rising edge
//  rst_i          in   1       reset, synchronous, active-high
//  flush_i        in   1       discard all buffered entries (synchronous)
//  in_valid_i     in   1       EX presents an entry
//  in_ready_o     out  1       buffer can accept this cycle
//  aluresult_i    in   DATA_W  ALU result
//  nzcv_i         in   FLAG_W  ALU flags
//  rs2data_i      in   DATA_W  store data
//  rd_i           in   RD_W    destination register
//  ctrl_i         in   CTRL_W  MEM/WB control bits
//  out_valid_o    out  1       entry available to MEM
//  out_ready_i    in   1       MEM consumes this cycle
//  aluresult_o    out  DATA_W  head entry result
//  nzcv_o         out  FLAG_W  head entry flags
//  rs2data_o      out  DATA_W  head entry store data
//  rd_o           out  RD_W    head entry destination
//  ctrl_o         out  CTRL_W  head entry control; forced 0 when out_valid_o=0
//  count_o        out  2       occupancy, 0..2
// BEHAVIOUR
//  - Accept = in_valid_i & in_ready_o. Take = out_valid_o & out_ready_i.
//  - States: EMPTY (count 0), ONE (main slot valid), TWO (main and skid valid).
//  - in_ready_o = (state != TWO), decoded from the state register only (no
//    input-to-ready combinational path). out_valid_o = (state != EMPTY).
//  - EMPTY: Accept -> ONE, main <= inputs.
//  - ONE: Accept and Take -> ONE, main <= inputs.
//    Accept only -> TWO, skid <= inputs.
//    Take only -> EMPTY.
//  - TWO: Take -> ONE, main <= skid. No Accept is possible (in_ready_o=0).
//  - Latency: an entry accepted at edge N is on the outputs after edge N (next cycle).
//  - Order is strictly FIFO. No entry is duplicated or lost unless flushed.
//  - Priority per edge: rst_i > flush_i > normal transitions.
//  - Flush: next state EMPTY, count_o 0. An Accept in the same cycle is dropped.
//    A Take in the same cycle still counts as consumed by MEM.
//  - Reset: state EMPTY and all data slots cleared to 0. Outputs during and
//    after reset: out_valid_o 0, ctrl_o 0, data outputs 0, count_o 0,
//    in_ready_o 1. Handshakes in a reset cycle are ignored. Reset mid-traffic
//    discards both slots.
//  - Data outputs hold their last value while out_valid_o=0; only ctrl_o is masked.
//  - count_o: 0, 1, 2 for EMPTY, ONE, TWO. It never wraps; state 2'b11 is unreachable.
// STRUCTURE
//  - Shared package risc_pkg: state encodings (EMPTY=2'd0, ONE=2'd1, TWO=2'd2),
//    CTRL bit indices (CTRL_MEMREAD=3 .. CTRL_MEMTOREG=0), FLAG_W/RD_W constants.
//  - One sub-module, ex_mem_slot: enable-loaded register holding the
//    {result, nzcv, rs2, rd, ctrl} bundle with sync clear. Instantiated twice
//    (main, skid). FSM and muxing stay in the top.
// TESTING
//  1 Reset for 2 cycles with in_valid_i=1 -> count_o 0, out_valid_o 0, ctrl_o 0,
//    in_ready_o 1.
//  2 Accept result 32'h0000_0005, rd 5'd3, ctrl 4'b0010 with out_ready_i=1 ->
//    out_valid_o next cycle with the same values; count_o returns to 0 after Take.
//  3 out_ready_i=0; push A=32'h11, then B=32'h22 -> count_o 2 and in_ready_o 0.
//    Raise out_ready_i -> A then B on consecutive cycles.
//  4 Back-to-back stream of 32'h1..32'h20 with out_ready_i toggling randomly ->
//    output order 1..32, none lost or duplicated, count_o never exceeds 2.
//  5 TWO state, then flush_i=1 with in_valid_i=1 (data 32'hDEAD) -> next cycle
//    count_o 0, out_valid_o 0, ctrl_o 0; 32'hDEAD never appears.
//  6 rst_i asserted while in state ONE holding 32'hBEEF -> next cycle EMPTY and
//    aluresult_o 0; the next Accept behaves as in scenario 2.

Source files
------------

// File: rtl/risc_pkg.sv
// ============================================================================
// Module : risc_pkg
// Brief  : Shared EX/MEM constants: buffer state encodings, control bit
//          indices and field widths.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package risc_pkg;

   typedef logic [1:0] skid_state_t;

   localparam skid_state_t ST_EMPTY = 2'd0;
   localparam skid_state_t ST_ONE   = 2'd1;
   localparam skid_state_t ST_TWO   = 2'd2;

   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_REGWRITE = 1;
   localparam int CTRL_MEMTOREG = 0;

   localparam int FLAG_W = 4;
   localparam int RD_W   = 5;

endpackage

`default_nettype wire

// File: rtl/ex_mem_skid_slot.sv
// ============================================================================
// Module : ex_mem_slot
// Brief  : Enable-loaded register holding one EX/MEM entry, with sync clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_slot #(
   parameter int DATA_W = 32,
   parameter int FLAG_W = 4,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 4
) (
   input  logic              clk_i,
   input  logic              clr_i,
   input  logic              ld_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic [FLAG_W-1:0] nzcv_i,
   input  logic [DATA_W-1:0] rs2_i,
   input  logic [RD_W-1:0]   rd_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic [DATA_W-1:0] result_o,
   output logic [FLAG_W-1:0] nzcv_o,
   output logic [DATA_W-1:0] rs2_o,
   output logic [RD_W-1:0]   rd_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   logic [DATA_W-1:0] result_q;
   logic [FLAG_W-1:0] nzcv_q;
   logic [DATA_W-1:0] rs2_q;
   logic [RD_W-1:0]   rd_q;
   logic [CTRL_W-1:0] ctrl_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         result_q <= '0;
         nzcv_q   <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         ctrl_q   <= '0;
      end else if (ld_i) begin
         result_q <= result_i;
         nzcv_q   <= nzcv_i;
         rs2_q    <= rs2_i;
         rd_q     <= rd_i;
         ctrl_q   <= ctrl_i;
      end
   end

   assign result_o = result_q;
   assign nzcv_o   = nzcv_q;
   assign rs2_o    = rs2_q;
   assign rd_o     = rd_q;
   assign ctrl_o   = ctrl_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_skid.sv
// ============================================================================
// Module : ex_mem_skid
// Brief  : Two-entry EX/MEM skid buffer; in_ready_o is decoded from state only.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_skid
   import risc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FLAG_W = risc_pkg::FLAG_W,
   parameter int RD_W   = risc_pkg::RD_W,
   parameter int CTRL_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] aluresult_i,
   input  logic [FLAG_W-1:0] nzcv_i,
   input  logic [DATA_W-1:0] rs2data_i,
   input  logic [RD_W-1:0]   rd_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] aluresult_o,
   output logic [FLAG_W-1:0] nzcv_o,
   output logic [DATA_W-1:0] rs2data_o,
   output logic [RD_W-1:0]   rd_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [1:0]        count_o
);

   skid_state_t state_q, state_d;
   logic        accept, take;
   logic        main_ld, skid_ld, main_from_skid;

   logic [DATA_W-1:0] main_res, skid_res, main_res_d;
   logic [FLAG_W-1:0] main_nzcv, skid_nzcv, main_nzcv_d;
   logic [DATA_W-1:0] main_rs2, skid_rs2, main_rs2_d;
   logic [RD_W-1:0]   main_rd, skid_rd, main_rd_d;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;

   assign in_ready_o  = (state_q != ST_TWO);
   assign out_valid_o = (state_q != ST_EMPTY);
   assign accept      = in_valid_i & in_ready_o;
   assign take        = out_valid_o & out_ready_i;

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      // Flush drops any same-cycle accept; a same-cycle take is simply consumed.
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  main_ld = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && take) begin
                  main_ld = 1'b1;
               end else if (accept) begin
                  state_d = ST_TWO;
                  skid_ld = 1'b1;
               end else if (take) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (take) begin
                  state_d        = ST_ONE;
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign main_res_d  = main_from_skid ? skid_res  : aluresult_i;
   assign main_nzcv_d = main_from_skid ? skid_nzcv : nzcv_i;
   assign main_rs2_d  = main_from_skid ? skid_rs2  : rs2data_i;
   assign main_rd_d   = main_from_skid ? skid_rd   : rd_i;
   assign main_ctrl_d = main_from_skid ? skid_ctrl : ctrl_i;

   ex_mem_slot #(
      .DATA_W (DATA_W),
      .FLAG_W (FLAG_W),
      .RD_W   (RD_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk_i    (clk_i),
      .clr_i    (rst_i),
      .ld_i     (main_ld),
      .result_i (main_res_d),
      .nzcv_i   (main_nzcv_d),
      .rs2_i    (main_rs2_d),
      .rd_i     (main_rd_d),
      .ctrl_i   (main_ctrl_d),
      .result_o (main_res),
      .nzcv_o   (main_nzcv),
      .rs2_o    (main_rs2),
      .rd_o     (main_rd),
      .ctrl_o   (main_ctrl)
   );

   ex_mem_slot #(
      .DATA_W (DATA_W),
      .FLAG_W (FLAG_W),
      .RD_W   (RD_W),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .clk_i    (clk_i),
      .clr_i    (rst_i),
      .ld_i     (skid_ld),
      .result_i (aluresult_i),
      .nzcv_i   (nzcv_i),
      .rs2_i    (rs2data_i),
      .rd_i     (rd_i),
      .ctrl_i   (ctrl_i),
      .result_o (skid_res),
      .nzcv_o   (skid_nzcv),
      .rs2_o    (skid_rs2),
      .rd_o     (skid_rd),
      .ctrl_o   (skid_ctrl)
   );

   // Data fields hold while empty; only the control bits are masked.
   assign aluresult_o = main_res;
   assign nzcv_o      = main_nzcv;
   assign rs2data_o   = main_rs2;
   assign rd_o        = main_rd;
   assign ctrl_o      = out_valid_o ? main_ctrl : '0;
   assign count_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_skid.sv
// ============================================================================
// Module : tb_ex_mem_skid
// Brief  : Self-checking bench for ex_mem_skid against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_skid;
   import risc_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  nzcv;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [3:0]  ctrl;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] aluresult_i = '0;
   logic [3:0]  nzcv_i = '0;
   logic [31:0] rs2data_i = '0;
   logic [4:0]  rd_i = '0;
   logic [3:0]  ctrl_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] aluresult_o;
   logic [3:0]  nzcv_o;
   logic [31:0] rs2data_o;
   logic [4:0]  rd_o;
   logic [3:0]  ctrl_o;
   logic [1:0]  count_o;

   int total = 0;
   int bad   = 0;

   ent_t q[$];
   ent_t shown = '0;
   int   next_val;
   int   seen_dead;

   ex_mem_skid dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .aluresult_i (aluresult_i),
      .nzcv_i      (nzcv_i),
      .rs2data_i   (rs2data_i),
      .rd_i        (rd_i),
      .ctrl_i      (ctrl_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .aluresult_o (aluresult_o),
      .nzcv_o      (nzcv_o),
      .rs2data_o   (rs2data_o),
      .rd_o        (rd_o),
      .ctrl_o      (ctrl_o),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count",     32'(count_o),     32'(n));
      chk("in_ready",  32'(in_ready_o),  32'(n < 2));
      chk("out_valid", 32'(out_valid_o), 32'(n > 0));
      chk("aluresult", aluresult_o,      shown.res);
      chk("nzcv",      32'(nzcv_o),      32'(shown.nzcv));
      chk("rs2data",   rs2data_o,        shown.rs2);
      chk("rd",        32'(rd_o),        32'(shown.rd));
      chk("ctrl",      32'(ctrl_o),      (n > 0) ? 32'(shown.ctrl) : 32'd0);
      if (out_valid_o === 1'b1 && aluresult_o == 32'hDEAD) seen_dead++;
   endtask

   function automatic ent_t rnd_ent();
      ent_t e;
      e.res  = $urandom;
      e.nzcv = 4'($urandom);
      e.rs2  = $urandom;
      e.rd   = 5'($urandom);
      e.ctrl = 4'($urandom);
      return e;
   endfunction

   function automatic ent_t mk(input logic [31:0] r, input logic [4:0] d, input logic [3:0] c);
      ent_t e;
      e      = rnd_ent();
      e.res  = r;
      e.rd   = d;
      e.ctrl = c;
      return e;
   endfunction

   // One clock: check at the negedge, drive, step the model across the posedge.
   task automatic cyc(input bit do_chk, input logic r, input logic f, input logic v,
                      input logic ord, input ent_t e);
      bit acc, tk;
      if (do_chk) check_all();
      rst_i       = r;
      flush_i     = f;
      in_valid_i  = v;
      out_ready_i = ord;
      aluresult_i = e.res;
      nzcv_i      = e.nzcv;
      rs2data_i   = e.rs2;
      rd_i        = e.rd;
      ctrl_i      = e.ctrl;
      acc = v && (q.size() < 2);
      tk  = ord && (q.size() > 0);
      @(posedge clk_i);
      if (r) begin
         q.delete();
         shown = '0;
      end else if (f) begin
         q.delete();
      end else begin
         if (tk) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            if (e.res == 32'(next_val)) next_val++;
         end
      end
      if (q.size() > 0) shown = q[0];
      @(negedge clk_i);
   endtask

   initial begin
      ent_t e;
      int   k;
      next_val  = 1;
      seen_dead = 0;
      @(negedge clk_i);

      // Reset with in_valid held high.
      cyc(0, 1, 0, 1, 0, mk(32'h77, 5'd1, 4'hF));
      cyc(1, 1, 0, 1, 0, mk(32'h77, 5'd1, 4'hF));
      check_all();
      chk("rst_ctrl_zero", 32'(ctrl_o), 32'd0);

      // Single entry through with MEM ready.
      cyc(1, 0, 0, 1, 1, mk(32'h5, 5'd3, 4'b0010));
      chk("s2_res", aluresult_o, 32'h5);
      chk("s2_rd", 32'(rd_o), 32'd3);
      chk("s2_ctrl", 32'(ctrl_o), 32'h2);
      cyc(1, 0, 0, 0, 1, '0);
      chk("s2_count", 32'(count_o), 32'd0);

      // Fill to TWO while stalled, then drain A then B.
      cyc(1, 0, 0, 1, 0, mk(32'h11, 5'd4, 4'b1010));
      cyc(1, 0, 0, 1, 0, mk(32'h22, 5'd5, 4'b0110));
      chk("s3_full", 32'(count_o), 32'd2);
      chk("s3_ready", 32'(in_ready_o), 32'd0);
      cyc(1, 0, 0, 1, 0, mk(32'h33, 5'd6, 4'b0001));
      chk("s3_headA", aluresult_o, 32'h11);
      cyc(1, 0, 0, 0, 1, '0);
      chk("s3_headB", aluresult_o, 32'h22);
      cyc(1, 0, 0, 0, 1, '0);

      // Stream 1..32 with random back-pressure.
      next_val = 1;
      k = 0;
      while ((next_val <= 32 || q.size() > 0) && k < 600) begin
         e = rnd_ent();
         e.res = 32'(next_val);
         cyc(1, 0, 0, next_val <= 32, 1'($urandom), e);
         chk("s4_count_le2", 32'(count_o <= 2'd2), 32'd1);
         k++;
      end
      chk("s4_stream_done", 32'(k < 600), 32'd1);

      // Flush out of TWO with a concurrent valid carrying 0xDEAD.
      cyc(1, 0, 0, 1, 0, mk(32'h44, 5'd7, 4'b1000));
      cyc(1, 0, 0, 1, 0, mk(32'h55, 5'd8, 4'b0100));
      cyc(1, 0, 1, 1, $urandom_range(0, 1) == 1, mk(32'hDEAD, 5'd9, 4'b1111));
      chk("s5_count", 32'(count_o), 32'd0);
      chk("s5_valid", 32'(out_valid_o), 32'd0);
      chk("s5_ctrl", 32'(ctrl_o), 32'd0);
      cyc(1, 0, 0, 0, 1, '0);

      // Reset while ONE holding 0xBEEF, then a normal accept.
      cyc(1, 0, 0, 1, 0, mk(32'hBEEF, 5'd10, 4'b0011));
      chk("s6_hold", aluresult_o, 32'hBEEF);
      cyc(1, 1, 0, 1, 1, mk(32'h66, 5'd11, 4'b0011));
      chk("s6_res0", aluresult_o, 32'h0);
      chk("s6_count", 32'(count_o), 32'd0);
      cyc(1, 0, 0, 1, 1, mk(32'h5, 5'd3, 4'b0010));
      chk("s6_res", aluresult_o, 32'h5);
      cyc(1, 0, 0, 0, 1, '0);

      // Random traffic including occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         cyc(1, ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
             1'($urandom), 1'($urandom), rnd_ent());
      end
      check_all();
      chk("no_dead_seen", 32'(seen_dead), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
